// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: funct3 codes, FSM encoding,
// byte-enable patterns and small helper functions.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // Width/alignment legality; the address range is checked separately.
  function automatic logic f3_ok(logic we, logic [2:0] f3, logic [1:0] a);
    case (f3)
      F3_B:    return 1'b1;
      F3_H:    return !a[0];
      F3_W:    return a == 2'b00;
      F3_BU:   return !we;
      F3_HU:   return !we && !a[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response channel between the core's data port (master) and the
// memory responder (slave).
interface dmem_if #(parameter int ADDR_W = 16);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_load_align.sv
// Load lane select and sign/zero extension of a 32-bit little-endian word.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    result = {{24{b[7]}}, b};
      F3_BU:   result = {24'd0, b};
      F3_H:    result = {{16{h[15]}}, h};
      F3_HU:   result = {16'd0, h};
      default: result = word;
    endcase
  end
endmodule

// File: rtl/dmem_responder.sv
// Word-addressed RAM behind a valid/ready load/store port with a fixed access
// latency. Define DMEM_STATS_EN to add saturating load/store/error counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic       clk,
  input  logic       rst,
  dmem_if.slave      bus
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0] load_cnt,
  output logic [15:0] store_cnt,
  output logic [15:0] err_cnt
`endif
);
  localparam int         IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  logic [1:0]        state;
  logic [3:0]        wait_cnt;
  logic              req_ready, rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_f3;
  logic [31:0]       r_wdata;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [IDX_W-1:0]  idx;
  logic              in_range, legal;
  logic [31:0]       rd_word, ld_data, wdata_rep;
  logic [3:0]        be;

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_err;

  assign idx      = r_addr[IDX_W+1:2];
  assign in_range = 32'(r_addr) < 32'(4 * DEPTH_WORDS);
  assign legal    = in_range && f3_ok(r_we, r_f3, r_addr[1:0]);
  assign rd_word  = mem[idx];

  dmem_load_align u_align (
    .word   (rd_word),
    .lane   (r_addr[1:0]),
    .funct3 (r_f3),
    .result (ld_data)
  );

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    case (r_f3)
      F3_B: begin
        be        = BE_B << r_addr[1:0];
        wdata_rep = {4{r_wdata[7:0]}};
      end
      F3_H: begin
        be        = BE_H << {r_addr[1], 1'b0};
        wdata_rep = {2{r_wdata[15:0]}};
      end
      default: begin
        be        = BE_W;
        wdata_rep = r_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == S_ACCESS && r_we && legal)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_f3      <= 3'd0;
      r_wdata   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (bus.req_valid) begin
            req_ready <= 1'b0;
            r_we      <= bus.req_we;
            r_addr    <= bus.req_addr;
            r_f3      <= bus.req_funct3;
            r_wdata   <= bus.req_wdata;
            wait_cnt  <= LAT;
            state     <= (LAT == 4'd0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) state <= S_ACCESS;
        end
        S_ACCESS: begin
          rsp_valid <= 1'b1;
          rsp_err   <= !legal;
          rsp_rdata <= (legal && !r_we) ? ld_data : 32'd0;
          state     <= S_RESP;
        end
        default: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt  <= 16'd0;
      store_cnt <= 16'd0;
      err_cnt   <= 16'd0;
    end else if (state == S_ACCESS) begin
      if (!legal)    err_cnt   <= sat_inc(err_cnt);
      else if (r_we) store_cnt <= sat_inc(store_cnt);
      else           load_cnt  <= sat_inc(load_cnt);
    end
  end
`endif

endmodule
